// File: rtl/wb_spi_sram_responder_if.sv
// rtl/wb_spi_sram_responder_if.sv - Wishbone slave bus and SPI pin bundle for wb_spi_sram_responder
interface wb_spi_sram_responder_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic [ADDR_WIDTH-1:0] wbs_adr_i;
    logic                  wbs_we_i;
    logic [7:0]            wbs_dat_i;
    logic                  wbs_ack_o;
    logic                  wbs_err_o;
    logic                  wbs_rty_o;
    logic [7:0]            wbs_dat_o;
    logic                  spi_sck_o;
    logic                  spi_cs_n_o;
    logic                  spi_mosi_o;
    logic                  spi_miso_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, spi_miso_i,
        output wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o, spi_sck_o, spi_cs_n_o, spi_mosi_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, spi_miso_i,
        input  wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o, spi_sck_o, spi_cs_n_o, spi_mosi_o
    );
endinterface

// File: rtl/wb_spi_sram_responder.sv
// rtl/wb_spi_sram_responder.sv - Wishbone byte slave backed by an SPI serial SRAM (one command per access)
// Optional sequential-mode streaming with CS held low: define SPI_SRAM_SEQ_EN.
module wb_spi_sram_responder #(
    parameter int ADDR_WIDTH = 24,
    parameter int CLK_DIV    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    wb_spi_sram_responder_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef SPI_SRAM_SEQ_EN
    typedef enum logic [2:0] {IDLE, SHIFT, ACK, RECOVER, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, ACK, RECOVER} state_t;
`endif

    state_t state_q, state_d;

    logic                  sck_q;
    logic                  cs_n_q;
    logic                  mosi_q;
    logic                  ack_q;
    logic [7:0]            dat_q;
    logic [39:0]           sh_q;
    logic [5:0]            bit_cnt_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [7:0]            rx_q;
    logic                  we_q;
    logic                  live_q;
`ifdef SPI_SRAM_SEQ_EN
    logic [23:0]           last_addr_q;
`endif

    logic [ADDR_WIDTH-1:0] adr;
    logic [23:0]           req_addr;
    logic                  sel;
    logic                  req;
    logic [7:0]            wbyte;
    logic [39:0]           load_word;
    logic                  div_done;
    logic                  shift_done;
    logic                  seq_hit;

    assign adr        = bus.wbs_adr_i;
    assign req_addr   = 24'(adr);
    assign sel        = bus.wbs_cyc_i && bus.wbs_stb_i;
    assign req        = sel && !ack_q;
    assign wbyte      = bus.wbs_we_i ? bus.wbs_dat_i : 8'h00;
    assign load_word  = {(bus.wbs_we_i ? 8'h02 : 8'h03), req_addr, wbyte};
    assign div_done   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign shift_done = (state_q == SHIFT) && div_done && sck_q && (bit_cnt_q == 6'd0);

`ifdef SPI_SRAM_SEQ_EN
    // The SRAM auto-increments in sequential mode, so only the next address with the same direction can stream on.
    assign seq_hit = req && (bus.wbs_we_i == we_q) && (req_addr == last_addr_q + 24'd1);
`else
    assign seq_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = ACK;
`ifdef SPI_SRAM_SEQ_EN
            ACK:     state_d = HOLD;
            HOLD:    if (req) state_d = seq_hit ? SHIFT : IDLE;
`else
            ACK:     state_d = RECOVER;
`endif
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 8'h00;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            rx_q      <= 8'h00;
            we_q      <= 1'b0;
            live_q    <= 1'b0;
`ifdef SPI_SRAM_SEQ_EN
            last_addr_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        sh_q      <= load_word;
                        mosi_q    <= load_word[39];
                        cs_n_q    <= 1'b0;
                        sck_q     <= 1'b0;
                        bit_cnt_q <= 6'd39;
                        div_cnt_q <= '0;
                        we_q      <= bus.wbs_we_i;
                        live_q    <= 1'b1;
`ifdef SPI_SRAM_SEQ_EN
                        last_addr_q <= req_addr;
`endif
                    end
                end
                SHIFT: begin
                    // A withdrawn request still finishes on the wire so writes are never torn.
                    if (!sel) live_q <= 1'b0;
                    if (div_done) begin
                        div_cnt_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[6:0], bus.spi_miso_i};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_cnt_q == 6'd0) begin
                                mosi_q <= 1'b0;
`ifndef SPI_SRAM_SEQ_EN
                                cs_n_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 6'd1;
                                sh_q      <= sh_q << 1;
                                mosi_q    <= sh_q[38];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    live_q <= 1'b0;
                    if (live_q && sel) begin
                        ack_q <= 1'b1;
                        if (!we_q) dat_q <= rx_q;
                    end
                end
`ifdef SPI_SRAM_SEQ_EN
                HOLD: begin
                    if (seq_hit) begin
                        sh_q        <= {wbyte, 32'h0000_0000};
                        mosi_q      <= wbyte[7];
                        sck_q       <= 1'b0;
                        bit_cnt_q   <= 6'd7;
                        div_cnt_q   <= '0;
                        live_q      <= 1'b1;
                        last_addr_q <= req_addr;
                    end else if (req) begin
                        cs_n_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.wbs_ack_o  = ack_q;
    assign bus.wbs_err_o  = 1'b0;
    assign bus.wbs_rty_o  = 1'b0;
    assign bus.wbs_dat_o  = dat_q;
    assign bus.spi_sck_o  = sck_q;
    assign bus.spi_cs_n_o = cs_n_q;
    assign bus.spi_mosi_o = mosi_q;
endmodule

// File: tb/tb_wb_spi_sram_responder.sv
// tb/tb_wb_spi_sram_responder.sv - directed self-checking bench with a behavioural SPI SRAM model
module tb_wb_spi_sram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miso = 1'b0;
    always #5 clk = ~clk;

    wb_spi_sram_responder_if #(.ADDR_WIDTH(24)) bus ();
    assign bus.spi_miso_i = miso;

    wb_spi_sram_responder #(.ADDR_WIDTH(24), .CLK_DIV(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

`ifdef SPI_SRAM_SEQ_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // SRAM model: unwritten bytes read back as addr[7:0] ^ 0x1F
    logic [7:0]  mem [int];
    int          pos = 0;
    int          rises = 0;
    int          sess_cnt = 0;
    int          seen_sess = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_adr = 24'h0;
    logic [7:0]  m_db = 8'h00;
    logic [63:0] mosi_sh = '0;

    int cs_low_cnt = 0;
    int hi_run = 0;
    int last_gap = 0;
    int ack_cnt = 0;

    function automatic logic [7:0] mem_rd(input int a);
        logic [23:0] a24;
        a24 = 24'(a);
        if (mem.exists(a)) return mem[a];
        return a24[7:0] ^ 8'h1F;
    endfunction

    always @(posedge bus.spi_sck_o) begin
        if (bus.spi_cs_n_o === 1'b0) begin
            if (seen_sess != sess_cnt) begin
                seen_sess = sess_cnt;
                pos = 0;
            end
            mosi_sh = {mosi_sh[62:0], bus.spi_mosi_o};
            rises++;
            if (pos < 8) m_cmd = {m_cmd[6:0], bus.spi_mosi_o};
            else if (pos < 32) m_adr = {m_adr[22:0], bus.spi_mosi_o};
            else begin
                m_db = {m_db[6:0], bus.spi_mosi_o};
                if ((pos - 32) % 8 == 7 && m_cmd == 8'h02) mem[int'(m_adr) + (pos - 32) / 8] = m_db;
            end
            pos++;
        end
    end

    always @(negedge bus.spi_sck_o) begin : drive_miso
        logic [7:0] b;
        if (bus.spi_cs_n_o === 1'b0 && pos >= 32 && m_cmd == 8'h03) begin
            b = mem_rd(int'(m_adr) + (pos - 32) / 8);
            miso = b[3'(7 - ((pos - 32) % 8))];
        end
    end

    always @(negedge clk) begin
        if (bus.spi_cs_n_o === 1'b0) begin
            cs_low_cnt++;
            if (hi_run > 0) begin
                last_gap = hi_run;
                hi_run = 0;
                sess_cnt++;
            end
        end else begin
            hi_run++;
        end
        if (bus.wbs_ack_o === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int snap_cs, snap_rise, snap_ack;

    task automatic wb_access(input logic we, input logic [23:0] adr, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
        logic got;
        @(posedge clk); #2;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        snap_cs   = cs_low_cnt;
        snap_rise = rises;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) check("ack_timeout", 64'(got), 64'd1);
        rd = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("ack_single_cycle", 64'(bus.wbs_ack_o), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    logic [7:0] rd;
    int         lat;

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 24'h0;
        bus.wbs_dat_i = 8'h00;

        @(posedge clk); #1;
        check("rst_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
        check("rst_sck",  64'(bus.spi_sck_o),  64'd0);
        check("rst_mosi", 64'(bus.spi_mosi_o), 64'd0);
        check("rst_ack",  64'(bus.wbs_ack_o),  64'd0);
        check("rst_dat",  64'(bus.wbs_dat_o),  64'h00);
        @(posedge clk); #2;
        rst = 1'b0;

        wb_access(1'b0, 24'h000123, 8'h00, rd, lat);
        check("rd123_lat",    64'(lat), 64'd81);
        check("rd123_data",   64'(rd), 64'h3C);
        check("rd123_mosi",   64'(mosi_sh[39:0]), 64'h03_000123_00);
        check("rd123_cs_low", 64'(cs_low_cnt - snap_cs), 64'(80 + EXTRA));
        check("rd123_rises",  64'(rises - snap_rise), 64'd40);
        check("err_rty",      64'({bus.wbs_err_o, bus.wbs_rty_o}), 64'd0);
        check("rd123_hold",   64'(bus.wbs_dat_o), 64'h3C);

        wb_access(1'b1, 24'h000123, 8'hA5, rd, lat);
        check("wr123_lat",   64'(lat), 64'(81 + EXTRA));
        check("wr123_mosi",  64'(mosi_sh[39:0]), 64'h02_000123_A5);
        check("wr123_rises", 64'(rises - snap_rise), 64'd40);
        check("wr123_mem",   64'(mem_rd(32'h123)), 64'hA5);
        check("wr_keeps_dat", 64'(bus.wbs_dat_o), 64'h3C);

        wb_access(1'b0, 24'h000123, 8'h00, rd, lat);
        check("rdback_data", 64'(rd), 64'hA5);

        do_reset();
        check("reset_clears_dat", 64'(bus.wbs_dat_o), 64'h00);
        wb_access(1'b0, 24'h000010, 8'h00, rd, lat);
        check("rd10_lat",  64'(lat), 64'd81);
        check("rd10_data", 64'(rd), 64'h0F);
        wb_access(1'b0, 24'h000011, 8'h00, rd, lat);
        check("rd11_data", 64'(rd), 64'h0E);
`ifdef SPI_SRAM_SEQ_EN
        check("rd11_lat",   64'(lat), 64'd17);
        check("rd11_rises", 64'(rises - snap_rise), 64'd8);
        check("rd11_mosi",  64'(mosi_sh[7:0]), 64'h00);
`else
        check("rd11_lat",    64'(lat), 64'd81);
        check("rd11_rises",  64'(rises - snap_rise), 64'd40);
        check("rd11_mosi",   64'(mosi_sh[39:0]), 64'h03_000011_00);
        check("cs_gap_ge2",  64'(last_gap >= 2), 64'd1);
`endif
        wb_access(1'b0, 24'h000040, 8'h00, rd, lat);
        check("rd40_data",  64'(rd), 64'h5F);
        check("rd40_lat",   64'(lat), 64'(81 + EXTRA));
        check("rd40_rises", 64'(rises - snap_rise), 64'd40);
        check("rd40_mosi",  64'(mosi_sh[39:0]), 64'h03_000040_00);
`ifdef SPI_SRAM_SEQ_EN
        check("rd40_cs_gap", 64'(last_gap), 64'd1);
`endif

        // Withdrawn read: transfer runs to completion, no ack, dat_o untouched
        @(posedge clk); #2;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 24'h000200;
        snap_rise = rises;
        snap_ack  = ack_cnt;
        repeat (10) @(posedge clk);
        #2;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("wd_no_ack",  64'(ack_cnt - snap_ack), 64'd0);
        check("wd_dat",     64'(bus.wbs_dat_o), 64'h5F);
        check("wd_rises",   64'(rises - snap_rise), 64'd40);
        check("wd_cs_n",    64'(bus.spi_cs_n_o), 64'(1 - EXTRA));

        // Reset in the middle of a write
        @(posedge clk); #2;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = 24'h000300;
        bus.wbs_dat_i = 8'hEE;
        snap_rise = rises;
        snap_ack  = ack_cnt;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (rises - snap_rise >= 20) break;
        end
        check("mid_reached_bit20", 64'(rises - snap_rise), 64'd20);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_cs_n", 64'(bus.spi_cs_n_o), 64'd1);
        check("mid_rst_sck",  64'(bus.spi_sck_o),  64'd0);
        check("mid_rst_mosi", 64'(bus.spi_mosi_o), 64'd0);
        check("mid_rst_ack",  64'(bus.wbs_ack_o),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid_no_ack",   64'(ack_cnt - snap_ack), 64'd0);
        check("mid_no_write", 64'(mem.exists(32'h300)), 64'd0);

        wb_access(1'b0, 24'h000124, 8'h00, rd, lat);
        check("post_rst_lat",  64'(lat), 64'd81);
        check("post_rst_data", 64'(rd), 64'h3B);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_spi_sram_responder.md
Name: wb_spi_sram_responder

Overview:
- Wishbone slave that serves byte reads and writes from the Levenshtein engine's Wishbone master, and from host test logic, using an external SPI serial SRAM (23LC1024-class).
- Each Wishbone access becomes one SPI command: READ 0x03 or WRITE 0x02, then a 24-bit address, then one data byte.
- Sits between the controller's master port and the chip's SPI pins. It holds both dictionary data and pattern-match vectors.

Parameters:
- ADDR_WIDTH, 24, Wishbone address width. Legal range 1..24. The address is zero-extended to 24 SPI address bits.
- CLK_DIV, 1, SCK half-period in clk_i cycles. Must be >= 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_adr_i  in  ADDR_WIDTH  byte address
- wbs_we_i  in  1  1 = write
- wbs_dat_i  in  8  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_err_o  out  1  tied 0
- wbs_rty_o  out  1  tied 0
- wbs_dat_o  out  8  read data; holds last read byte
- spi_sck_o  out  1  SPI clock, mode 0
- spi_cs_n_o  out  1  chip select, active low
- spi_mosi_o  out  1  serial data to SRAM
- spi_miso_i  in  1  serial data from SRAM

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is synchronous, active-high (rst_i).
- Values after reset:
  - wbs_ack_o=0, wbs_dat_o=0x00
  - spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0
  - FSM in IDLE
- States: IDLE, SHIFT, ACK, RECOVER (plus HOLD with the optional feature).
- IDLE:
  - A request is wbs_cyc_i & wbs_stb_i & !wbs_ack_o.
  - On a request: latch address, we and write data. Build a 40-bit shift word {cmd, addr24, wdata}; wdata=0x00 for reads. Go to SHIFT.
  - On that same edge: spi_cs_n_o=0 and spi_mosi_o = shift-word bit 39.
- SHIFT:
  - Each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high. Bits are sent MSB first.
  - MISO is sampled on the SCK rising edge. MOSI advances on the SCK falling edge.
  - The last 8 sampled MISO bits form the read byte.
  - A bit counter tracks 40 bits. After the high phase of bit 0: SCK=0, CS=1, go to ACK.
  - CS therefore falls at request edge N and rises at edge N+80*CLK_DIV.
- ACK:
  - wbs_ack_o=1 for exactly one cycle.
  - On reads, wbs_dat_o is updated on the same edge ack rises.
  - Next state RECOVER.
- RECOVER: one cycle with CS high, then IDLE. Minimum CS-high time is 2 cycles. Request-to-ack latency is 80*CLK_DIV+1 cycles.
- wbs_dat_o is unchanged by writes.
- Request withdrawn mid-transfer (cyc or stb low before ACK): the SPI transfer still completes. Writes are never torn. wbs_ack_o is suppressed and wbs_dat_o is not updated.
- A new request is only accepted in IDLE. A request held during ACK or RECOVER is taken as a new access once back in IDLE.
- rst_i asserted mid-transfer: at the next edge, all outputs return to reset values and CS rises. A partial write is abandoned.
- Address: the top 24-ADDR_WIDTH bits are 0. No wrap handling is needed in non-sequential mode.

Optional Feature:
- Macro: SPI_SRAM_SEQ_EN
- Defined:
  - After RECOVER-less completion, CS stays low in HOLD, with the SRAM in sequential mode (its power-on default).
  - A new request with the same we and address == last+1 (mod 2^24) shifts only the 8 data bits. Latency is 16*CLK_DIV+1.
  - Any other request raises CS for 1 cycle, then runs a full 40-bit transfer.
  - Exiting HOLD on a non-matching request costs exactly 1 extra cycle.
  - Reset exits HOLD with CS=1.
- Undefined: every access is a full 40-bit transfer and HOLD does not exist.

Test Plan:
- Reset with CLK_DIV=1 -> cs_n=1, sck=0, ack=0, dat_o=0x00 immediately after the first reset edge.
- Write 0xA5 to 0x000123 -> MOSI shows 0x02, 0x000123, 0xA5 over 40 SCK pulses. CS is low for exactly 80 cycles. ack is 1 cycle at N+81.
- Read 0x000123 with the SRAM model returning 0x3C -> MOSI shows 0x03, 0x000123. dat_o=0x3C while ack is high and afterwards. err=rty=0.
- Back-to-back reads of 0x10 then 0x11 (macro off) -> two full transfers with CS high ≥2 cycles between them.
- Macro on: read 0x10, read 0x11, read 0x40 -> 2nd access shows 8 SCK pulses with no command, ack at +17. 3rd access raises CS for 1 cycle, then a full transfer.
- rst_i pulsed at SHIFT bit 20 of a write -> next edge cs_n=1, no ack. A following read works normally.
